// File: rtl/core_pkg.sv
// Shared constants for the pipelined ARM core front end.
package core_pkg;

  // MOV r0, r0: the architectural no-op injected as a pipeline bubble.
  localparam logic [31:0] NOP_INSTR            = 32'hE1A0_0000;
  localparam logic [31:0] PC_INC               = 32'd4;
  // R15 reads as the instruction address plus eight on this core.
  localparam logic [31:0] R15_OFFSET           = 32'd8;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Hazard, redirect, instruction-memory and Decode-side signals of the fetch stage.
interface fetch_decode_stage_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             PCSrcW;
  logic             BranchE;
  logic             CondEx;
  logic [31:0]      ALUResultE;
  logic [31:0]      ResultW;
  logic [31:0]      InstrF;
  logic             cnt_clr;
  logic [31:0]      PCF;
  logic [31:0]      InstrD;
  logic [31:0]      PCPlus8D;
  logic             ValidD;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  // Surrounding pipeline / instruction memory side.
  modport master (
    output StallF, StallD, FlushD, PCSrcW, BranchE, CondEx,
    output ALUResultE, ResultW, InstrF, cnt_clr,
    input  PCF, InstrD, PCPlus8D, ValidD, StallCnt, FlushCnt
  );

  // Fetch stage side.
  modport slave (
    input  StallF, StallD, FlushD, PCSrcW, BranchE, CondEx,
    input  ALUResultE, ResultW, InstrF, cnt_clr,
    output PCF, InstrD, PCPlus8D, ValidD, StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_reg_enc.sv
// Pipeline flop with async reset, synchronous clear and load enable.
// Clear beats enable so a flush overrides a stall.
module pipe_reg_enc #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d;
  logic [Width-1:0] data_q;

  // Next value: clear to the reset value, else load when enabled, else hold.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = ResetVal;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= ResetVal;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage: PC register, next-PC select and IF/ID pipeline register,
// plus saturating stall/flush event counters for performance debug.
module fetch_decode_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_stage_if.slave bus
);

  localparam logic [31:0] PcfResetVal = {RESET_VECTOR[31:2], 2'b00};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic        branch_taken;
  logic        redirect;
  logic        pcf_en;
  logic [31:0] pcf;
  logic [31:0] pc_next;
  logic [31:0] pc_plus8;
  logic        ifid_en;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  assign branch_taken = bus.BranchE & bus.CondEx;
  assign redirect     = branch_taken | bus.PCSrcW;
  // A redirect must land even during a load-use stall, or it would be lost.
  assign pcf_en       = ~bus.StallF | redirect;
  assign ifid_en      = ~bus.StallD;
  assign pc_plus8     = pcf + R15_OFFSET;

  // Next-PC select: branch target beats writeback, which beats sequential fetch.
  always_comb begin
    pc_next = pcf + PC_INC;
    if (branch_taken) begin
      pc_next = bus.ALUResultE;
    end else if (bus.PCSrcW) begin
      pc_next = bus.ResultW;
    end
    pc_next[1:0] = 2'b00;
  end

  pipe_reg_enc #(
    .Width    (32),
    .ResetVal (PcfResetVal)
  ) u_pcf (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pcf_en),
    .clr_i (1'b0),
    .d_i   (pc_next),
    .q_o   (pcf)
  );

  pipe_reg_enc #(
    .Width    (32),
    .ResetVal (NOP_INSTR)
  ) u_instr_d (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ifid_en),
    .clr_i (bus.FlushD),
    .d_i   (bus.InstrF),
    .q_o   (bus.InstrD)
  );

  pipe_reg_enc #(
    .Width    (32),
    .ResetVal (32'h0)
  ) u_pc_plus8_d (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ifid_en),
    .clr_i (bus.FlushD),
    .d_i   (pc_plus8),
    .q_o   (bus.PCPlus8D)
  );

  pipe_reg_enc #(
    .Width    (1),
    .ResetVal (1'b0)
  ) u_valid_d (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ifid_en),
    .clr_i (bus.FlushD),
    .d_i   (1'b1),
    .q_o   (bus.ValidD)
  );

  // Counter next state: clear wins, otherwise count the event until saturated.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (bus.StallD && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (bus.FlushD && (flush_cnt_q != CntMax)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCF      = pcf;
  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: vector table plus hand sequences
// for counter saturation/clear and asynchronous reset mid-stall.
module tb_fetch_decode_stage;

  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  fetch_decode_stage_if #(.CNT_W(CW)) bus ();

  fetch_decode_stage #(
    .RESET_VECTOR (32'h0000_0100),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory: data is a tag plus the address.
  assign bus.InstrF = 32'hAAAA_0000 + bus.PCF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, fd, pcw, be, ce;
    logic [31:0] alu, res;
    logic [31:0] e_pcf, e_instr, e_p8;
    logic        e_v;
    logic [31:0] e_sc, e_fc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                         input logic [31:0] p8, input logic v, input logic [31:0] sc,
                         input logic [31:0] fc);
    chk({tag, ".PCF"}, bus.PCF, pcf);
    chk({tag, ".InstrD"}, bus.InstrD, instr);
    chk({tag, ".PCPlus8D"}, bus.PCPlus8D, p8);
    chk({tag, ".ValidD"}, {31'd0, bus.ValidD}, {31'd0, v});
    chk({tag, ".StallCnt"}, {28'd0, bus.StallCnt}, sc);
    chk({tag, ".FlushCnt"}, {28'd0, bus.FlushCnt}, fc);
  endtask

  task automatic idle_inputs();
    bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.PCSrcW = 0;
    bus.BranchE = 0; bus.CondEx = 0; bus.ALUResultE = '0; bus.ResultW = '0;
    bus.cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    //          sf sd fd pw be ce alu            res            pcf            instr          p8             v  sc fc
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h104,       32'hAAAA_0100, 32'h108,       1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h108,       32'hAAAA_0104, 32'h10C,       1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h10C,       32'hAAAA_0108, 32'h110,       1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h110,       32'hAAAA_010C, 32'h114,       1, 0, 0};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h110,       32'hAAAA_010C, 32'h114,       1, 1, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h110,       32'hAAAA_010C, 32'h114,       1, 2, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h114,       32'hAAAA_0110, 32'h118,       1, 2, 0};
    vecs[7]  = '{0, 0, 1, 0, 1, 1, 32'h2003,     32'h0,         32'h2000,      32'hE1A0_0000, 32'h0,         0, 2, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h2004,      32'hAAAA_2000, 32'h2008,      1, 2, 1};
    vecs[9]  = '{0, 0, 0, 0, 1, 0, 32'h3000,     32'h0,         32'h2008,      32'hAAAA_2004, 32'h200C,      1, 2, 1};
    vecs[10] = '{1, 1, 1, 1, 0, 0, 32'h0,        32'h400,       32'h400,       32'hE1A0_0000, 32'h0,         0, 3, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h404,       32'hAAAA_0400, 32'h408,       1, 3, 2};
    vecs[12] = '{0, 0, 0, 1, 1, 1, 32'h500,      32'h600,       32'h500,       32'hAAAA_0404, 32'h40C,       1, 3, 2};
    vecs[13] = '{0, 0, 0, 1, 0, 0, 32'h0,        32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hAAAA_0500, 32'h508,       1, 3, 2};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'hAAA9_FFFC, 32'h4,         1, 3, 2};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h4,         32'hAAAA_0000, 32'h8,         1, 3, 2};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h4,         32'hAAAA_0004, 32'hC,         1, 3, 2};

    idle_inputs();
    rst_n = 0;
    step();
    step();
    chk_all("reset", 32'h100, 32'hE1A0_0000, 32'h0, 1'b0, 0, 0);
    rst_n = 1;

    for (int i = 0; i < 17; i++) begin
      bus.StallF = vecs[i].sf;  bus.StallD = vecs[i].sd;  bus.FlushD = vecs[i].fd;
      bus.PCSrcW = vecs[i].pcw; bus.BranchE = vecs[i].be; bus.CondEx = vecs[i].ce;
      bus.ALUResultE = vecs[i].alu; bus.ResultW = vecs[i].res;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_instr, vecs[i].e_p8,
              vecs[i].e_v, vecs[i].e_sc, vecs[i].e_fc);
    end

    // Stall counter saturation: starts at 3, hits 15 after 12 cycles, then stays.
    idle_inputs();
    bus.StallF = 1;
    bus.StallD = 1;
    for (int i = 0; i < 12; i++) step();
    chk("sat12.StallCnt", {28'd0, bus.StallCnt}, 32'd15);
    for (int i = 0; i < 8; i++) step();
    chk("sat20.StallCnt", {28'd0, bus.StallCnt}, 32'd15);
    chk("sat20.PCF", bus.PCF, 32'h4);
    bus.cnt_clr = 1;
    step();
    chk("clr.StallCnt", {28'd0, bus.StallCnt}, 32'd0);
    chk("clr.FlushCnt", {28'd0, bus.FlushCnt}, 32'd0);
    bus.cnt_clr = 0;
    step();
    chk("postclr.StallCnt", {28'd0, bus.StallCnt}, 32'd1);

    // Asynchronous reset in the middle of a stall, between clock edges.
    #2;
    rst_n = 0;
    #1;
    chk_all("async_rst", 32'h100, 32'hE1A0_0000, 32'h0, 1'b0, 0, 0);
    step();
    idle_inputs();
    rst_n = 1;
    #1;
    chk("release.PCF", bus.PCF, 32'h100);
    step();
    chk_all("first_fetch", 32'h104, 32'hAAAA_0100, 32'h108, 1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage pipelined ARM core. Sits directly downstream of the hazard unit and consumes its StallF, StallD and FlushD outputs.
- Holds the PC and selects the next PC from the branch target (E), the writeback result (W) or PC+4.
- Latches the fetched instruction into Decode with stall/flush semantics.
- Carries saturating stall/flush event counters for performance debug.

Parameters:
RESET_VECTOR, 32'h0000_0000, PCF value loaded on reset.
CNT_W, 16, width of each event counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
StallF  input  1  from hazard unit; hold PCF
StallD  input  1  from hazard unit; hold IF/ID register
FlushD  input  1  from hazard unit; load bubble into IF/ID register
PCSrcW  input  1  PC-writing instruction retiring in W
BranchE  input  1  branch instruction in E
CondEx  input  1  condition passed for instruction in E
ALUResultE  input  32  branch target from E
ResultW  input  32  writeback value destined for R15
InstrF  input  32  instruction memory read data for address PCF
cnt_clr  input  1  synchronous clear of both event counters
PCF  output  32  current fetch address to instruction memory
InstrD  output  32  instruction in Decode
PCPlus8D  output  32  R15 read value for the instruction in Decode
ValidD  output  1  InstrD is a real instruction, not a bubble
StallCnt  output  CNT_W  cycles with StallD=1, saturating
FlushCnt  output  CNT_W  cycles with FlushD=1, saturating

Behaviour:
- Reset is asynchronous and active-low; it has priority over every other input. Reset values:
  - PCF = RESET_VECTOR with bits [1:0] forced to 0.
  - InstrD = NOP_INSTR (32'hE1A0_0000).
  - PCPlus8D = 0, ValidD = 0, StallCnt = 0, FlushCnt = 0.
- BranchTakenE = BranchE & CondEx, computed internally.
- Next-PC priority:
  1. BranchTakenE -> ALUResultE
  2. else PCSrcW -> ResultW
  3. else PCF + 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0)
- Bits [1:0] of the next PC are always forced to 0.
- PCF update rule:
  - A redirect (BranchTakenE or PCSrcW) loads PCF even when StallF=1.
  - Otherwise PCF holds when StallF=1 and loads PCF+4 when StallF=0.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD=1: InstrD <= NOP_INSTR, ValidD <= 0, PCPlus8D <= 0.
  - StallD=1 (no flush): InstrD, PCPlus8D and ValidD hold.
  - Otherwise: InstrD <= InstrF, PCPlus8D <= PCF + 8 (mod 2^32), ValidD <= 1.
- Latency:
  - An instruction at address A is visible on InstrD one cycle after PCF=A with StallF=0.
  - Instruction memory is combinational: InstrF is valid in the same cycle as PCF.
- Counters:
  - StallCnt increments by 1 each cycle StallD=1.
  - FlushCnt increments by 1 each cycle FlushD=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 zeroes both counters and beats any increment in the same cycle.
  - Counters have no effect on datapath behaviour.
- Simultaneous events:
  - StallF=1 with PCSrcW=1 (load-use stall coincident with PC write): PCF takes ResultW. FlushD wins over StallD in Decode.
  - BranchTakenE with PCSrcW: the branch target wins.
- Reset asserted mid-stall or mid-flush: all state returns to reset values immediately; the first fetch after release is at RESET_VECTOR.
- Outputs are registers only; no combinational path from inputs to PCF, InstrD, PCPlus8D or ValidD.

Decomposition:
- Shared package (core_pkg):
  - NOP_INSTR = 32'hE1A0_0000
  - PC_INC = 4
  - R15_OFFSET = 8
  - default RESET_VECTOR
- One natural sub-module: pipe_reg_enc, a width-parameterised flop with async active-low reset, enable (active when not stalled), synchronous clear and a reset-value parameter.
  - Instantiated for PCF and for each IF/ID field.
  - For PCF, clear is unused; enable = ~StallF | redirect.

Test Plan:
- Reset release with RESET_VECTOR=32'h100, no stalls, InstrF=32'hAAAA_0000+PCF -> PCF steps 100, 104, 108. InstrD = AAAA_0100 one cycle after PCF=100, with PCPlus8D=108 and ValidD=1.
- StallF=StallD=1 for 2 cycles at PCF=110 -> PCF stays 110 and InstrD/PCPlus8D/ValidD unchanged for 2 cycles. StallCnt=2, then fetch resumes at 114.
- BranchE=CondEx=1, ALUResultE=32'h2003, FlushD=1 -> next PCF=2000, InstrD=E1A00000, ValidD=0, FlushCnt +1. With CondEx=0, PCF=PC+4 and no redirect.
- StallF=StallD=FlushD=1 with PCSrcW=1, ResultW=32'h400 -> PCF=400 next cycle, ValidD=0 (flush beats stall).
- PCF=32'hFFFF_FFFC, no stall -> PCF=0 next cycle and PCPlus8D=32'h0000_0004 for that instruction. With CNT_W=4 and StallD held 20 cycles, StallCnt saturates at 15; cnt_clr=1 with StallD=1 gives 0.
- rst_n pulsed low asynchronously mid-stall -> all outputs at reset values before the next clk edge; PCF=RESET_VECTOR after release.
